cache_bus_arbiter: RTL and testbench

Arbitrates line-fill (load) and write-back (store) commands from `CONNECTIONS` cache ports onto the single AXI bus engine. The engine holds the line buffer and drives the AXI channels. The arbiter grants one cache at a time and holds the grant for the entire transaction, from command issue through engine completion to the response handshake with the cache. Selection is round-robin by default; fixed lowest-index priority is available as a build option. The block sits between the caches and the bus engine and supplies the engine's `cacheID`.

---
 rtl/cache_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
//   Grants one of CONNECTIONS cache ports access to the shared AXI bus
//   engine and holds that grant for the whole transaction: command issue,
//   engine completion, and the response handshake back to the cache.
//   Selection is round-robin starting at rr_ptr. Defining the build macro
//   CACHE_BUS_ARB_FIXED_PRIO_EN switches to fixed lowest-index priority
//   and removes the round-robin pointer.
//
// Ports
//   clk, reset                  rising-edge clock, async active-low reset
//   req_valid/store/addr        per-cache command request (held until req_ready)
//   req_ready                   one-hot accept strobe, IDLE only
//   rsp_valid / rsp_ready       one-hot completion to the granted cache
//   eng_cmd_valid/ready         command handshake to the engine
//   eng_cmd_store/addr/id       latched command fields, id = granted cache
//   eng_done_valid/ready        engine completion handshake, WAIT only
//   busy                        high whenever the FSM is not IDLE
module cache_bus_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int CONNECTIONS = 2,
    parameter int ID_W        = $clog2(CONNECTIONS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CONNECTIONS-1:0]                req_valid,
    input  logic [CONNECTIONS-1:0]                req_store,
    input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] req_addr,
    output logic [CONNECTIONS-1:0]                req_ready,
    output logic [CONNECTIONS-1:0]                rsp_valid,
    input  logic [CONNECTIONS-1:0]                rsp_ready,
    output logic                                  eng_cmd_valid,
    input  logic                                  eng_cmd_ready,
    output logic                                  eng_cmd_store,
    output logic [ADDR_WIDTH-1:0]                 eng_cmd_addr,
    output logic [ID_W-1:0]                       eng_cmd_id,
    input  logic                                  eng_done_valid,
    output logic                                  eng_done_ready,
    output logic                                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CONNECTIONS-1:0] ONE = CONNECTIONS'(1);

    state_t          state;
    logic [ID_W-1:0] win_id;
    logic            any_req;

    assign any_req = |req_valid;

`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        win_id = '0;
        for (int k = CONNECTIONS - 1; k >= 0; k--) begin
            if (req_valid[k]) win_id = ID_W'(k);
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    int              rr_dist;
    int              rr_best;

    // Each requester's distance from rr_ptr going upward with wrap; the
    // smallest distance wins. Constant indices keep this loop free of
    // out-of-range selects when CONNECTIONS is not a power of two.
    always_comb begin
        win_id  = '0;
        rr_dist = 0;
        rr_best = CONNECTIONS;
        for (int k = 0; k < CONNECTIONS; k++) begin
            rr_dist = (k >= int'(rr_ptr)) ? (k - int'(rr_ptr))
                                          : (k + CONNECTIONS - int'(rr_ptr));
            if (req_valid[k] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                win_id  = ID_W'(k);
            end
        end
    end
`endif

    // Accept strobe is combinational so the grant happens in the same cycle
    // the request is seen. It is gated by reset so every output reads 0
    // while reset is held, even with requests pending.
    assign req_ready = (reset && (state == IDLE) && any_req) ? (ONE << win_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            eng_cmd_valid  <= 1'b0;
            eng_cmd_store  <= 1'b0;
            eng_cmd_addr   <= '0;
            eng_cmd_id     <= '0;
            eng_done_ready <= 1'b0;
            rsp_valid      <= '0;
            busy           <= 1'b0;
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
            rr_ptr         <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        eng_cmd_store <= req_store[win_id];
                        eng_cmd_addr  <= req_addr[win_id];
                        eng_cmd_id    <= win_id;
                        eng_cmd_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
`ifndef CACHE_BUS_ARB_FIXED_PRIO_EN
                        // Explicit wrap: natural overflow is wrong when
                        // CONNECTIONS is not a power of two.
                        rr_ptr <= (win_id == ID_W'(CONNECTIONS - 1)) ? '0
                                                                    : win_id + ID_W'(1);
`endif
                    end
                end
                ISSUE: begin
                    if (eng_cmd_ready) begin
                        eng_cmd_valid  <= 1'b0;
                        eng_done_ready <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done_valid) begin
                        eng_done_ready <= 1'b0;
                        rsp_valid      <= ONE << eng_cmd_id;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    // rsp_valid is one-hot on the grant, so masking with it
                    // drops rsp_ready from non-granted caches.
                    if (|(rsp_ready & rsp_valid)) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
module tb_cache_bus_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       req_valid, req_store, req_ready, rsp_valid, rsp_ready;
    logic [1:0][63:0] req_addr;
    logic             eng_cmd_valid, eng_cmd_ready, eng_cmd_store;
    logic [63:0]      eng_cmd_addr;
    logic [0:0]       eng_cmd_id;
    logic             eng_done_valid, eng_done_ready, busy;

    logic [2:0]       req_valid3, req_store3, req_ready3, rsp_valid3, rsp_ready3;
    logic [2:0][63:0] req_addr3;
    logic             eng_cmd_valid3, eng_cmd_ready3, eng_cmd_store3;
    logic [63:0]      eng_cmd_addr3;
    logic [1:0]       eng_cmd_id3;
    logic             eng_done_valid3, eng_done_ready3, busy3;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_addr [2];
    logic        exp_store [2];
    int          fair_exp [4];
    int          exp3 [4];
    int          bp_exp, stray_exp;

    cache_bus_arbiter #(.ADDR_WIDTH(64), .CONNECTIONS(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
        .eng_cmd_store(eng_cmd_store), .eng_cmd_addr(eng_cmd_addr),
        .eng_cmd_id(eng_cmd_id), .eng_done_valid(eng_done_valid),
        .eng_done_ready(eng_done_ready), .busy(busy)
    );

    cache_bus_arbiter #(.ADDR_WIDTH(64), .CONNECTIONS(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid3), .req_store(req_store3), .req_addr(req_addr3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .eng_cmd_valid(eng_cmd_valid3), .eng_cmd_ready(eng_cmd_ready3),
        .eng_cmd_store(eng_cmd_store3), .eng_cmd_addr(eng_cmd_addr3),
        .eng_cmd_id(eng_cmd_id3), .eng_done_valid(eng_done_valid3),
        .eng_done_ready(eng_done_ready3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One full transaction on the 2-port DUT, entered and left at a negedge
    // with the FSM in IDLE. Waits stretch each handshake; stray pulses
    // eng_done_valid in ISSUE and the other cache's rsp_ready in RESP.
    task automatic run_txn(input string tag, input logic [1:0] rv, input int exp_id,
                           input int cmd_wait, input int done_wait, input int rsp_wait,
                           input bit stray);
        logic [1:0] oh;
        oh = '0;
        oh[exp_id] = 1'b1;
        req_valid = rv;
        #1;
        chk({tag, ":accept"}, req_ready, oh);
        chk({tag, ":idle_busy"}, busy, 0);
        @(negedge clk);
        for (int i = 0; i <= cmd_wait; i++) begin
            eng_cmd_ready  = (i == cmd_wait);
            eng_done_valid = stray && (i == 0) && (cmd_wait > 0);
            #1;
            chk({tag, ":cmd_valid"}, eng_cmd_valid, 1);
            chk({tag, ":cmd_addr"}, eng_cmd_addr, exp_addr[exp_id]);
            chk({tag, ":cmd_store"}, eng_cmd_store, exp_store[exp_id]);
            chk({tag, ":cmd_id"}, eng_cmd_id, exp_id);
            chk({tag, ":issue_no_accept"}, req_ready, 0);
            chk({tag, ":issue_done_rdy"}, eng_done_ready, 0);
            chk({tag, ":busy"}, busy, 1);
            @(negedge clk);
        end
        eng_cmd_ready  = 1'b0;
        eng_done_valid = 1'b0;
        for (int i = 0; i <= done_wait; i++) begin
            eng_done_valid = (i == done_wait);
            #1;
            chk({tag, ":wait_done_rdy"}, eng_done_ready, 1);
            chk({tag, ":wait_cmd_valid"}, eng_cmd_valid, 0);
            chk({tag, ":wait_rsp"}, rsp_valid, 0);
            @(negedge clk);
        end
        eng_done_valid = 1'b0;
        for (int i = 0; i <= rsp_wait; i++) begin
            rsp_ready = (i == rsp_wait) ? oh : (stray ? ~oh : 2'b00);
            #1;
            chk({tag, ":rsp_valid"}, rsp_valid, oh);
            chk({tag, ":rsp_no_accept"}, req_ready, 0);
            chk({tag, ":rsp_done_rdy"}, eng_done_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 2'b00;
        #1;
        chk({tag, ":rsp_drop"}, rsp_valid, 0);
        chk({tag, ":busy_drop"}, busy, 0);
    endtask

    initial begin
        exp_addr[0]  = 64'h1000;  exp_addr[1]  = 64'h2040;
        exp_store[0] = 1'b0;      exp_store[1] = 1'b1;
`ifdef CACHE_BUS_ARB_FIXED_PRIO_EN
        fair_exp = '{0, 0, 0, 0};
        exp3     = '{0, 0, 0, 0};
        bp_exp    = 0;
        stray_exp = 0;
`else
        fair_exp = '{0, 1, 0, 1};
        exp3     = '{0, 1, 2, 0};
        bp_exp    = 0;
        stray_exp = 1;
`endif
        reset = 1'b0;
        req_valid = 2'b11;
        req_store = {exp_store[1], exp_store[0]};
        req_addr[0] = exp_addr[0];
        req_addr[1] = exp_addr[1];
        rsp_ready = 2'b00;
        eng_cmd_ready = 1'b0;
        eng_done_valid = 1'b0;
        req_valid3 = 3'b000;
        req_store3 = 3'b010;
        req_addr3[0] = 64'hA000; req_addr3[1] = 64'hB000; req_addr3[2] = 64'hC000;
        rsp_ready3 = 3'b000;
        eng_cmd_ready3 = 1'b0;
        eng_done_valid3 = 1'b0;

        // Reset state, with requests pending
        @(negedge clk); @(negedge clk); #1;
        chk("rst:req_ready", req_ready, 0);
        chk("rst:busy", busy, 0);
        chk("rst:cmd_valid", eng_cmd_valid, 0);
        chk("rst:cmd_addr", eng_cmd_addr, 0);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;

        // Single load from cache 0, done 5 cycles after WAIT entry
        run_txn("load", 2'b01, 0, 0, 5, 0, 1'b0);

        // Grant cache 1 and reset in WAIT
        req_valid = 2'b10;
        #1;
        chk("mid:accept", req_ready, 2'b10);
        @(negedge clk);
        eng_cmd_ready = 1'b1;
        @(negedge clk);
        eng_cmd_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("mid:wait_done_rdy", eng_done_ready, 1);
        chk("mid:id", eng_cmd_id, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst:req_ready", req_ready, 0);
        chk("mid_rst:rsp_valid", rsp_valid, 0);
        chk("mid_rst:cmd_valid", eng_cmd_valid, 0);
        chk("mid_rst:cmd_store", eng_cmd_store, 0);
        chk("mid_rst:cmd_addr", eng_cmd_addr, 0);
        chk("mid_rst:cmd_id", eng_cmd_id, 0);
        chk("mid_rst:done_rdy", eng_done_ready, 0);
        chk("mid_rst:busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst:accept", req_ready, 2'b01);
        chk("post_rst:busy", busy, 0);

        // Both caches requesting continuously
        for (int n = 0; n < 4; n++) run_txn($sformatf("fair%0d", n), 2'b11, fair_exp[n], 0, 0, 0, 1'b0);

        // Command and response backpressure
        run_txn("bp", 2'b11, bp_exp, 4, 0, 3, 1'b0);

        // Stray done in ISSUE, stray rsp_ready from the other cache in RESP
        run_txn("stray", 2'b11, stray_exp, 2, 1, 2, 1'b1);
        req_valid = 2'b00;

        // 3-port wrap with zero-wait engine and caches: accept every 4 cycles
        @(negedge clk);
        eng_cmd_ready3 = 1'b1;
        eng_done_valid3 = 1'b1;
        rsp_ready3 = 3'b111;
        req_valid3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            logic [2:0] o3;
            o3 = '0;
            o3[exp3[k]] = 1'b1;
            #1;
            chk($sformatf("rr3_%0d:accept", k), req_ready3, o3);
            @(negedge clk); #1;
            chk($sformatf("rr3_%0d:id", k), eng_cmd_id3, exp3[k]);
            chk($sformatf("rr3_%0d:addr", k), eng_cmd_addr3, req_addr3[exp3[k]]);
            @(negedge clk); @(negedge clk); #1;
            chk($sformatf("rr3_%0d:rsp", k), rsp_valid3, o3);
            @(negedge clk);
        end
        req_valid3 = 3'b000;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
